// File: rtl/rat_nway.sv
// rat_nway: N-way register alias table (architectural -> physical rename).
// Renames up to WAYS instructions per cycle. Free tags are handed out in
// order to the ways that actually write a register. Sources and old
// mappings are forwarded from older ways in the same group. The table is
// restored from the retirement map (rrat_map) on flush.
// Optional feature: define RAT_CHECKPOINT_EN to add NUM_CKPT snapshot slots
// with take/restore ports.
module rat_nway #(
    parameter int WAYS     = 2,
    parameter int ARF_SIZE = 32,
    parameter int PRF_SIZE = 64,
    parameter int ZERO_REG = 31,
    parameter int NUM_CKPT = 4,
    localparam int ARF_IDX = $clog2(ARF_SIZE),
    localparam int PRF_IDX = $clog2(PRF_SIZE),
    localparam int CNT_W   = $clog2(WAYS + 1)
`ifdef RAT_CHECKPOINT_EN
    ,
    localparam int CKPT_IDX = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         flush,
    input  logic [ARF_SIZE*PRF_IDX-1:0]  rrat_map,
    input  logic [WAYS-1:0]              id_valid,
    input  logic [WAYS*ARF_IDX-1:0]      id_rega,
    input  logic [WAYS*ARF_IDX-1:0]      id_regb,
    input  logic [WAYS*ARF_IDX-1:0]      id_dest,
    input  logic [WAYS*PRF_IDX-1:0]      free_tag,
    input  logic [CNT_W-1:0]             free_cnt,
    output logic                         stall,
    output logic [CNT_W-1:0]             alloc_cnt,
    output logic [WAYS*PRF_IDX-1:0]      rs_prega,
    output logic [WAYS*PRF_IDX-1:0]      rs_pregb,
    output logic [WAYS*PRF_IDX-1:0]      rob_pdest,
    output logic [WAYS*PRF_IDX-1:0]      rob_pold,
    output logic [WAYS-1:0]              out_valid,
    output logic [ARF_SIZE*PRF_IDX-1:0]  map_dbg
`ifdef RAT_CHECKPOINT_EN
    ,
    input  logic                         ckpt_take,
    input  logic [CKPT_IDX-1:0]          ckpt_slot,
    input  logic                         ckpt_rest,
    input  logic [CKPT_IDX-1:0]          rest_slot
`endif
);

    localparam logic [ARF_IDX-1:0] ZERO_IDX = ARF_IDX'(ZERO_REG);

    logic [PRF_IDX-1:0] map_r      [ARF_SIZE];
    logic [PRF_IDX-1:0] map_next_s [ARF_SIZE];

    logic [ARF_IDX-1:0] dest_s [WAYS];
    logic [ARF_IDX-1:0] srca_s [WAYS];
    logic [ARF_IDX-1:0] srcb_s [WAYS];
    logic [CNT_W-1:0]   kidx_s [WAYS];
    logic [PRF_IDX-1:0] pdest_s [WAYS];
    logic [PRF_IDX-1:0] pold_s  [WAYS];
    logic [PRF_IDX-1:0] pa_s    [WAYS];
    logic [PRF_IDX-1:0] pb_s    [WAYS];

    logic [WAYS-1:0]         need_s;
    logic [CNT_W-1:0]        total_s;
    logic                    stall_s;
    logic                    rest_s;
    logic                    go_s;
    logic [WAYS*PRF_IDX-1:0] pa_flat_s;
    logic [WAYS*PRF_IDX-1:0] pb_flat_s;
    logic [WAYS*PRF_IDX-1:0] pd_flat_s;
    logic [WAYS*PRF_IDX-1:0] po_flat_s;

`ifdef RAT_CHECKPOINT_EN
    logic [PRF_IDX-1:0] ckpt_r [NUM_CKPT][ARF_SIZE];
    assign rest_s = ckpt_rest;
`else
    assign rest_s = 1'b0;
`endif

    // Unpack ID fields, mark ways that write a register, count tags used by older ways.
    always_comb begin
        total_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            dest_s[w] = id_dest[w*ARF_IDX +: ARF_IDX];
            srca_s[w] = id_rega[w*ARF_IDX +: ARF_IDX];
            srcb_s[w] = id_regb[w*ARF_IDX +: ARF_IDX];
            need_s[w] = id_valid[w] && (dest_s[w] != ZERO_IDX);
            kidx_s[w] = total_s;
            if (need_s[w]) begin
                total_s = total_s + CNT_W'(1);
            end else begin
                total_s = total_s;
            end
        end
    end

    // Group control: stall when the group needs more tags than are offered.
    always_comb begin
        stall_s = en && !flush && (total_s > free_cnt);
        go_s    = en && !flush && !rest_s && !stall_s;
        if (go_s) begin
            alloc_cnt = total_s;
        end else begin
            alloc_cnt = '0;
        end
        stall = stall_s;
    end

    // Rename each way with intra-group forwarding; build the post-group map.
    // Zero-register destinations never set need, so zero-register sources
    // can never match a forwarding candidate and always read map[ZERO_REG].
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (need_s[w]) begin
                pdest_s[w] = free_tag[int'(kidx_s[w])*PRF_IDX +: PRF_IDX];
                pold_s[w]  = map_r[dest_s[w]];
            end else begin
                pdest_s[w] = map_r[ZERO_IDX];
                pold_s[w]  = map_r[ZERO_IDX];
            end
            pa_s[w] = map_r[srca_s[w]];
            pb_s[w] = map_r[srcb_s[w]];
            // Ascending scan: a younger older-way match overrides an earlier one.
            for (int j = 0; j < w; j++) begin
                if (need_s[j] && (dest_s[j] == srca_s[w])) begin
                    pa_s[w] = pdest_s[j];
                end else begin
                    pa_s[w] = pa_s[w];
                end
                if (need_s[j] && (dest_s[j] == srcb_s[w])) begin
                    pb_s[w] = pdest_s[j];
                end else begin
                    pb_s[w] = pb_s[w];
                end
                if (need_s[w] && need_s[j] && (dest_s[j] == dest_s[w])) begin
                    pold_s[w] = pdest_s[j];
                end else begin
                    pold_s[w] = pold_s[w];
                end
            end
        end
        map_next_s = map_r;
        for (int w = 0; w < WAYS; w++) begin
            if (need_s[w]) begin
                map_next_s[dest_s[w]] = pdest_s[w];
            end else begin
                map_next_s[dest_s[w]] = map_next_s[dest_s[w]];
            end
        end
    end

    // Flatten per-way results and the current map for the output ports.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            pa_flat_s[w*PRF_IDX +: PRF_IDX] = pa_s[w];
            pb_flat_s[w*PRF_IDX +: PRF_IDX] = pb_s[w];
            pd_flat_s[w*PRF_IDX +: PRF_IDX] = pdest_s[w];
            po_flat_s[w*PRF_IDX +: PRF_IDX] = pold_s[w];
        end
        for (int i = 0; i < ARF_SIZE; i++) begin
            map_dbg[i*PRF_IDX +: PRF_IDX] = map_r[i];
        end
    end

    // Mapping table: identity on reset, RRAT on flush, snapshot on restore, else rename.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARF_SIZE; i++) begin
                map_r[i] <= PRF_IDX'(i);
            end
        end else if (flush) begin
            for (int i = 0; i < ARF_SIZE; i++) begin
                map_r[i] <= rrat_map[i*PRF_IDX +: PRF_IDX];
            end
`ifdef RAT_CHECKPOINT_EN
        end else if (rest_s) begin
            map_r <= ckpt_r[rest_slot];
`endif
        end else if (go_s) begin
            map_r <= map_next_s;
        end
    end

    // Registered rename results toward RS/ROB; dropped groups clear out_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= '0;
            rs_prega  <= '0;
            rs_pregb  <= '0;
            rob_pdest <= '0;
            rob_pold  <= '0;
        end else if (flush || rest_s) begin
            out_valid <= '0;
        end else if (en && stall_s) begin
            out_valid <= '0;
        end else if (go_s) begin
            out_valid <= id_valid;
            rs_prega  <= pa_flat_s;
            rs_pregb  <= pb_flat_s;
            rob_pdest <= pd_flat_s;
            rob_pold  <= po_flat_s;
        end
    end

`ifdef RAT_CHECKPOINT_EN
    // Snapshot storage: a take captures the map as it will look after this group.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                for (int i = 0; i < ARF_SIZE; i++) begin
                    ckpt_r[s][i] <= PRF_IDX'(i);
                end
            end
        end else if (ckpt_take && en && !flush && !stall_s) begin
            ckpt_r[ckpt_slot] <= map_next_s;
        end
    end
`endif

endmodule

// File: tb/tb_rat_nway.sv
// Directed bench for rat_nway (WAYS=2, ARF 32, PRF 64, zero reg 31).
// Expected rename results are queued when a group is driven and compared
// against the registered outputs one edge later.
module tb_rat_nway;
    localparam int AI = 5;
    localparam int PI = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic            en;
    logic            flush;
    logic [32*PI-1:0] rrat_map;
    logic [1:0]      id_valid;
    logic [2*AI-1:0] id_rega;
    logic [2*AI-1:0] id_regb;
    logic [2*AI-1:0] id_dest;
    logic [2*PI-1:0] free_tag;
    logic [1:0]      free_cnt;
    logic            stall;
    logic [1:0]      alloc_cnt;
    logic [2*PI-1:0] rs_prega;
    logic [2*PI-1:0] rs_pregb;
    logic [2*PI-1:0] rob_pdest;
    logic [2*PI-1:0] rob_pold;
    logic [1:0]      out_valid;
    logic [32*PI-1:0] map_dbg;

    typedef struct packed {
        logic            chk_data;
        logic [1:0]      ov;
        logic [2*PI-1:0] pa;
        logic [2*PI-1:0] pb;
        logic [2*PI-1:0] pd;
        logic [2*PI-1:0] po;
    } exp_t;

    exp_t sb[$];
    exp_t grp_a;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    rat_nway dut (
        .clock(clock), .reset(reset), .en(en), .flush(flush),
        .rrat_map(rrat_map), .id_valid(id_valid), .id_rega(id_rega),
        .id_regb(id_regb), .id_dest(id_dest), .free_tag(free_tag),
        .free_cnt(free_cnt), .stall(stall), .alloc_cnt(alloc_cnt),
        .rs_prega(rs_prega), .rs_pregb(rs_pregb), .rob_pdest(rob_pdest),
        .rob_pold(rob_pold), .out_valid(out_valid), .map_dbg(map_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mp(input int i);
        return 32'(map_dbg[i*PI +: PI]);
    endfunction

    function automatic exp_t mk(input logic c, input logic [1:0] ov,
                                input int pa0, input int pa1, input int pb0, input int pb1,
                                input int pd0, input int pd1, input int po0, input int po1);
        exp_t e;
        e.chk_data = c;
        e.ov = ov;
        e.pa = {PI'(pa1), PI'(pa0)};
        e.pb = {PI'(pb1), PI'(pb0)};
        e.pd = {PI'(pd1), PI'(pd0)};
        e.po = {PI'(po1), PI'(po0)};
        return e;
    endfunction

    task automatic drive(input logic e, input logic f, input logic [1:0] v,
                         input int d0, input int a0, input int b0,
                         input int d1, input int a1, input int b1,
                         input int t0, input int t1, input int cnt);
        en       = e;
        flush    = f;
        id_valid = v;
        id_dest  = {AI'(d1), AI'(d0)};
        id_rega  = {AI'(a1), AI'(a0)};
        id_regb  = {AI'(b1), AI'(b0)};
        free_tag = {PI'(t1), PI'(t0)};
        free_cnt = 2'(cnt);
        #1;
    endtask

    task automatic tick_and_check();
        exp_t e;
        @(posedge clock);
        @(negedge clock);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("out_valid", 32'(out_valid), 32'(e.ov));
            if (e.chk_data) begin
                check("rs_prega",  32'(rs_prega),  32'(e.pa));
                check("rs_pregb",  32'(rs_pregb),  32'(e.pb));
                check("rob_pdest", 32'(rob_pdest), 32'(e.pd));
                check("rob_pold",  32'(rob_pold),  32'(e.po));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rrat_map = '0;
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state: identity map, outputs cleared
        for (int i = 0; i < 32; i++) check($sformatf("reset_map%0d", i), mp(i), 32'(i));
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_rs_prega", 32'(rs_prega), 32'd0);
        check("reset_rob_pold", 32'(rob_pold), 32'd0);

        // A: r1<-r2+r3 | r4<-r1+r1, free 40,41
        drive(1'b1, 1'b0, 2'b11, 1, 2, 3, 4, 1, 1, 40, 41, 2);
        check("A_stall", 32'(stall), 32'd0);
        check("A_alloc", 32'(alloc_cnt), 32'd2);
        grp_a = mk(1'b1, 2'b11, 2, 40, 3, 40, 40, 41, 1, 4);
        sb.push_back(grp_a);
        tick_and_check();
        check("A_map1", mp(1), 32'd40);
        check("A_map4", mp(4), 32'd41);

        // en=0: table and registered outputs hold
        drive(1'b0, 1'b0, 2'b11, 12, 1, 1, 13, 1, 1, 44, 45, 2);
        check("hold_stall", 32'(stall), 32'd0);
        check("hold_alloc", 32'(alloc_cnt), 32'd0);
        sb.push_back(grp_a);
        tick_and_check();
        check("hold_map12", mp(12), 32'd12);

        // B: both ways write r5; way1 reads r5
        drive(1'b1, 1'b0, 2'b11, 5, 6, 7, 5, 5, 8, 42, 43, 2);
        check("B_alloc", 32'(alloc_cnt), 32'd2);
        sb.push_back(mk(1'b1, 2'b11, 6, 42, 7, 8, 42, 43, 5, 42));
        tick_and_check();
        check("B_map5", mp(5), 32'd43);

        // C: way0 invalid, way1 r7<-r1+r31, one free tag
        drive(1'b1, 1'b0, 2'b10, 9, 2, 3, 7, 1, 31, 50, 63, 1);
        check("C_stall", 32'(stall), 32'd0);
        check("C_alloc", 32'(alloc_cnt), 32'd1);
        sb.push_back(mk(1'b1, 2'b10, 2, 40, 3, 31, 31, 50, 31, 7));
        tick_and_check();
        check("C_map7", mp(7), 32'd50);
        check("C_map9", mp(9), 32'd9);

        // D: both ways target r31 with no free tags: no allocation, no stall
        drive(1'b1, 1'b0, 2'b11, 31, 4, 2, 31, 5, 6, 0, 0, 0);
        check("D_stall", 32'(stall), 32'd0);
        check("D_alloc", 32'(alloc_cnt), 32'd0);
        sb.push_back(mk(1'b1, 2'b11, 41, 43, 2, 6, 31, 31, 31, 31));
        tick_and_check();
        check("D_map31", mp(31), 32'd31);

        // E: two needing ways, one free tag -> stall
        drive(1'b1, 1'b0, 2'b11, 10, 1, 1, 11, 1, 1, 60, 61, 1);
        check("E_stall", 32'(stall), 32'd1);
        check("E_alloc", 32'(alloc_cnt), 32'd0);
        sb.push_back(mk(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tick_and_check();
        check("E_map10", mp(10), 32'd10);
        check("E_map11", mp(11), 32'd11);

        // Flush with rrat_map[i] = i+32 drops the same-cycle group
        for (int i = 0; i < 32; i++) rrat_map[i*PI +: PI] = PI'(i + 32);
        drive(1'b1, 1'b1, 2'b11, 13, 1, 1, 14, 1, 1, 20, 21, 2);
        check("F_stall", 32'(stall), 32'd0);
        check("F_alloc", 32'(alloc_cnt), 32'd0);
        sb.push_back(mk(1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        tick_and_check();
        check("F_map3", mp(3), 32'd35);
        check("F_map1", mp(1), 32'd33);
        check("F_map13", mp(13), 32'd45);

        // G: rename after flush reads the restored map
        drive(1'b1, 1'b0, 2'b01, 2, 3, 1, 0, 0, 0, 20, 21, 1);
        check("G_alloc", 32'(alloc_cnt), 32'd1);
        sb.push_back(mk(1'b1, 2'b01, 35, 32, 33, 32, 20, 63, 34, 63));
        tick_and_check();
        check("G_map2", mp(2), 32'd20);

        // Reset beats flush
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 3, 1, 1, 4, 1, 1, 22, 23, 2);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("R_map3", mp(3), 32'd3);
        check("R_out_valid", 32'(out_valid), 32'd0);
        check("R_rs_prega", 32'(rs_prega), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
